// File: rtl/bcd_stopwatch_ctrl.sv
// Stopwatch sequencer: prescaled tick, start/stop/clear/lap FSM and a saturating
// cascaded BCD counter whose value (or a held lap snapshot) drives the display.
module bcd_stopwatch_ctrl #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned PRESCALE = 10
) (
  input  logic                clk,
  input  logic                rst_asyn,
  input  logic                start_stop,
  input  logic                clear,
  input  logic                lap,
  output logic [4*DIGITS-1:0] Q_out,
  output logic                running,
  output logic                overflow
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PscLast = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {StIdle, StRun, StPause, StOvf} state_t;

  state_t          state;
  logic [W-1:0]    count;
  logic [W-1:0]    lap_reg;
  logic            lap_hold;
  logic [PW-1:0]   psc;
  logic            ss_d;
  logic            clr_d;
  logic            lap_d;

  logic            ss_evt;
  logic            clr_evt;
  logic            lap_evt;
  logic            tick;
  logic [W-1:0]    count_inc;
  logic            all_nines;

  assign ss_evt  = start_stop & ~ss_d;
  assign clr_evt = clear & ~clr_d;
  assign lap_evt = lap & ~lap_d;
  assign tick    = (state == StRun) && (psc == PscLast);

  // Ripple increment; the carry surviving past the top digit means the count was all 9s.
  always_comb begin
    count_inc = count;
    all_nines = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (all_nines) begin
        if (count[4*i +: 4] == 4'd9) begin
          count_inc[4*i +: 4] = 4'd0;
        end else begin
          count_inc[4*i +: 4] = count[4*i +: 4] + 4'd1;
          all_nines           = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst_asyn) begin
    if (rst_asyn) begin
      state    <= StIdle;
      count    <= '0;
      lap_reg  <= '0;
      lap_hold <= 1'b0;
      psc      <= '0;
      ss_d     <= 1'b0;
      clr_d    <= 1'b0;
      lap_d    <= 1'b0;
    end else begin
      ss_d  <= start_stop;
      clr_d <= clear;
      lap_d <= lap;
      if (clr_evt) begin
        state    <= StIdle;
        count    <= '0;
        psc      <= '0;
        lap_hold <= 1'b0;
      end else begin
        if (state == StRun) begin
          psc <= tick ? '0 : psc + PW'(1);
        end
        // Snapshot uses the pre-increment count when a tick coincides.
        if (lap_evt && (state == StRun || state == StPause)) begin
          if (!lap_hold) begin
            lap_reg  <= count;
            lap_hold <= 1'b1;
          end else begin
            lap_hold <= 1'b0;
          end
        end
        unique case (state)
          StIdle: begin
            if (ss_evt) state <= StRun;
          end
          StRun: begin
            if (tick && !all_nines) count <= count_inc;
            if (tick && all_nines) begin
              state <= StOvf;
            end else if (ss_evt) begin
              state <= StPause;
            end
          end
          StPause: begin
            if (ss_evt) state <= StRun;
          end
          StOvf: begin
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

  assign Q_out    = lap_hold ? lap_reg : count;
  assign running  = (state == StRun);
  assign overflow = (state == StOvf);

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Directed bench for bcd_stopwatch_ctrl with DIGITS=2, PRESCALE=2.
module tb_bcd_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       rst_asyn;
  logic       start_stop;
  logic       clear;
  logic       lap;
  logic [7:0] q_out;
  logic       running;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  bcd_stopwatch_ctrl #(
    .DIGITS  (2),
    .PRESCALE(2)
  ) dut (
    .clk       (clk),
    .rst_asyn  (rst_asyn),
    .start_stop(start_stop),
    .clear     (clear),
    .lap       (lap),
    .Q_out     (q_out),
    .running   (running),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Each pulse is high across exactly one rising edge.
  task automatic pulse_ss();
    start_stop = 1'b1;
    step(1);
    start_stop = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step(1);
    clear = 1'b0;
  endtask

  task automatic pulse_lap();
    lap = 1'b1;
    step(1);
    lap = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_asyn   = 1'b1;
    start_stop = 1'b0;
    clear      = 1'b0;
    lap        = 1'b0;
    step(2);
    check("rst_q", q_out, 8'h00);
    check("rst_run", running, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    rst_asyn = 1'b0;
    step(1);

    // 1: count with carry into digit 1
    pulse_ss();
    check("t1_run", running, 1'b1);
    check("t1_q0", q_out, 8'h00);
    step(2);
    check("t1_q1", q_out, 8'h01);
    step(16);
    check("t1_q9", q_out, 8'h09);
    step(2);
    check("t1_q10", q_out, 8'h10);

    // 2: pause freezes; resume keeps prescaler phase (next edge ticks)
    pulse_ss();
    check("t2_pause_run", running, 1'b0);
    check("t2_pause_q", q_out, 8'h10);
    step(10);
    check("t2_frozen", q_out, 8'h10);
    pulse_ss();
    check("t2_resume_run", running, 1'b1);
    check("t2_resume_q", q_out, 8'h10);
    step(1);
    check("t2_phase", q_out, 8'h11);

    // 4: lap hold and release
    pulse_clear();
    check("t4_clr_q", q_out, 8'h00);
    check("t4_clr_run", running, 1'b0);
    pulse_ss();
    step(10);
    check("t4_q5", q_out, 8'h05);
    pulse_lap();
    check("t4_hold", q_out, 8'h05);
    step(11);
    check("t4_held", q_out, 8'h05);
    check("t4_still_run", running, 1'b1);
    pulse_lap();
    check("t4_release", q_out, 8'h11);

    // 5: clear beats start_stop on the same edge
    clear      = 1'b1;
    start_stop = 1'b1;
    step(1);
    clear      = 1'b0;
    start_stop = 1'b0;
    check("t5_q", q_out, 8'h00);
    check("t5_run", running, 1'b0);
    step(4);
    check("t5_idle_q", q_out, 8'h00);

    // lap in IDLE is ignored
    pulse_lap();
    pulse_ss();
    step(2);
    check("idle_lap_ign", q_out, 8'h01);
    pulse_clear();

    // 3: saturate at 99 and overflow
    pulse_ss();
    step(198);
    check("t3_q99", q_out, 8'h99);
    check("t3_pre_ovf", overflow, 1'b0);
    step(2);
    check("t3_sat", q_out, 8'h99);
    check("t3_ovf", overflow, 1'b1);
    check("t3_ovf_run", running, 1'b0);
    pulse_ss();
    step(3);
    check("t3_ss_ign", overflow, 1'b1);
    check("t3_ss_ign_run", running, 1'b0);
    pulse_lap();
    check("t3_lap_ign", q_out, 8'h99);
    pulse_clear();
    check("t3_clr_q", q_out, 8'h00);
    check("t3_clr_ovf", overflow, 1'b0);

    // 6: async reset mid-run, start_stop held through release
    pulse_ss();
    step(74);
    check("t6_q37", q_out, 8'h37);
    #2;
    start_stop = 1'b1;
    rst_asyn   = 1'b1;
    #1;
    check("t6_async_q", q_out, 8'h00);
    check("t6_async_run", running, 1'b0);
    @(negedge clk);
    rst_asyn = 1'b0;
    #1;
    check("t6_rel_run", running, 1'b0);
    step(1);
    check("t6_first_edge", running, 1'b1);
    check("t6_first_q", q_out, 8'h00);
    start_stop = 1'b0;
    step(2);
    check("t6_count", q_out, 8'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
